gamma_lut_mapper: RTL and testbench
===================================

Name: gamma_lut_mapper

Overview:
- Runtime-programmable, pipelined gamma/tone-curve mapper for the video pipeline.
- Replaces fixed per-curve combinational case tables with a single double-buffered RAM LUT of 2^DATA_WIDTH entries.
- The LUT is shared by CHANNELS parallel pixel components.
- Host writes a new curve into the shadow bank; it becomes active only at a frame boundary, so no frame is mapped with a mixed table.

Parameters:
- DATA_WIDTH, 8, bits per pixel component; LUT depth is 2^DATA_WIDTH.
- CHANNELS, 3, number of components per pixel; all use the same curve.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- per_frame_vsync  in  1  input frame sync, active high.
- per_frame_href  in  1  input line valid.
- per_frame_clken  in  1  input pixel valid strobe.
- per_img_data  in  CHANNELS*DATA_WIDTH  input pixel; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- post_frame_vsync  out  1  vsync delayed 2 cycles.
- post_frame_href  out  1  href delayed 2 cycles.
- post_frame_clken  out  1  clken delayed 2 cycles.
- post_img_data  out  CHANNELS*DATA_WIDTH  mapped pixel, same packing as per_img_data.
- cfg_we  in  1  write strobe; writes cfg_data to shadow bank at cfg_addr.
- cfg_addr  in  DATA_WIDTH  LUT entry index (input code).
- cfg_data  in  DATA_WIDTH  LUT entry value (output code).
- cfg_swap_req  in  1  single-cycle pulse requesting bank swap.
- bypass_en  in  1  1 = identity mapping; sampled per pixel.
- cfg_swap_pending  out  1  swap requested, not yet committed.
- cfg_active_bank  out  1  bank currently used for mapping.
- cfg_table_valid  out  1  at least one swap committed since reset.

Behaviour:
- Storage: 2 banks x 2^DATA_WIDTH x DATA_WIDTH. Shadow bank = ~cfg_active_bank. RAM contents are not reset.
- Config writes:
  - cfg_we always targets the shadow bank, in any state, including while a swap is pending.
  - A write is visible to mapping only after a later commit.
- Swap state machine, two states:
  - IDLE: cfg_swap_req moves to PENDING and sets cfg_swap_pending.
  - PENDING: on a detected vsync rising edge (per_frame_vsync=1 while the previous-cycle sample was 0), commit: toggle cfg_active_bank, set cfg_table_valid=1, clear cfg_swap_pending, return to IDLE.
  - cfg_swap_req in PENDING is ignored; no double toggle.
  - cfg_swap_req in the same cycle as a vsync rising edge while IDLE: commit at that edge; pending is never observed high.
  - The new bank takes effect for the pixel sampled in the commit cycle and all later pixels.
- Mapping pipeline, fixed latency 2 cycles, runs every cycle regardless of clken:
  - Stage 1: register the input pixel and sync signals; issue CHANNELS read addresses to the active bank.
  - Stage 2: register LUT read data and sync signals.
  - Per-pixel mode is resolved in stage 1: if bypass_en=1 or cfg_table_valid=0, the output equals the input (identity); otherwise the output equals LUT[active][in] per channel.
  - Bank select and mode are captured with the pixel, so changing bypass_en or committing a swap never corrupts an in-flight pixel.
  - post_img_data is forced to 0 when post_frame_clken=0.
- No arithmetic beyond indexing: output width equals input width, with no saturation or rounding.
- Reset (asynchronous, may occur mid-frame or mid-swap):
  - All post_* outputs = 0.
  - cfg_active_bank = 0, cfg_swap_pending = 0, cfg_table_valid = 0, vsync edge register = 0.
  - Any pending swap is discarded.
  - After release, output is identity until the first commit.
  - If vsync is high at release, no edge is detected until vsync has gone low and then high.
- Multi-read implementation: CHANNELS read ports per bank are allowed (replicated or multi-port RAM); behaviour must be identical for all channels.

Test Plan:
- Reset, no swap, bypass_en=0: pixel {0x80,0x10,0xFF} with clken=1 -> same value on post_img_data 2 cycles later; sync outputs are inputs delayed 2 cycles; cfg_table_valid=0.
- Load 256-entry gamma-2.2 curve, pulse cfg_swap_req, then raise vsync -> pending high until the edge, then cfg_active_bank=1 and cfg_table_valid=1; inputs 0x80/0x40/0xFF/0x0F map to 0x38/0x0C/0xFF/0x01.
- Mid-frame cfg_swap_req after loading inverse curve (LUT[i]=255-i) into bank 0 -> current frame keeps mapping 0x80->0x38; from the next vsync rising edge 0x80->0x7F; write during PENDING to entry 0x80=0x11 is honoured (0x80->0x11).
- cfg_swap_req in the same cycle as a vsync rising edge -> commit that cycle; a second cfg_swap_req during PENDING -> exactly one bank toggle.
- bypass_en toggled every pixel on a line with table valid -> alternating identity/mapped outputs, aligned 2 cycles late; clken=0 cycles -> post_img_data=0.
- Assert rst_n mid-line with swap pending -> all outputs 0 immediately; after release, identity mapping, bank 0, no spurious commit although vsync is high at release.

Source files
------------

// File: rtl/gamma_lut_mapper.sv
// gamma_lut_mapper: double-buffered RAM LUT tone-curve mapper with frame-boundary bank swap
module gamma_lut_mapper #(
    parameter int DATA_WIDTH = 8,
    parameter int CHANNELS   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           per_frame_vsync,
    input  logic                           per_frame_href,
    input  logic                           per_frame_clken,
    input  logic [CHANNELS*DATA_WIDTH-1:0] per_img_data,
    output logic                           post_frame_vsync,
    output logic                           post_frame_href,
    output logic                           post_frame_clken,
    output logic [CHANNELS*DATA_WIDTH-1:0] post_img_data,
    input  logic                           cfg_we,
    input  logic [DATA_WIDTH-1:0]          cfg_addr,
    input  logic [DATA_WIDTH-1:0]          cfg_data,
    input  logic                           cfg_swap_req,
    input  logic                           bypass_en,
    output logic                           cfg_swap_pending,
    output logic                           cfg_active_bank,
    output logic                           cfg_table_valid
);
    localparam int DEPTH = 1 << DATA_WIDTH;
    localparam int PW    = CHANNELS * DATA_WIDTH;

    typedef enum logic {S_IDLE, S_PEND} state_t;

    state_t                  r_state, w_state_nxt;
    logic                    r_vs_d, r_vs_armed, r_bank, r_valid;
    logic [DATA_WIDTH-1:0]   r_lut [2][DEPTH];
    logic [PW-1:0]           r_s1_data, r_post_data, w_lut_data;
    logic                    r_s1_bank, r_s1_map, r_s1_vsync, r_s1_href, r_s1_clken;
    logic                    r_post_vsync, r_post_href, r_post_clken;
    logic                    w_vs_rise, w_commit;

    // An edge only counts once vsync has been seen low after reset
    assign w_vs_rise = per_frame_vsync & ~r_vs_d & r_vs_armed;
    assign w_commit  = w_vs_rise & ((r_state == S_PEND) | cfg_swap_req);

    // Swap FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Swap FSM next state: commit wins, otherwise a request parks us in PENDING
    always_comb w_state_nxt = w_commit ? S_IDLE : (cfg_swap_req ? S_PEND : r_state);

    // Swap FSM outputs
    always_comb cfg_swap_pending = (r_state == S_PEND);

    // Vsync edge detector, active bank and table-valid flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vs_d     <= 1'b0;
            r_vs_armed <= 1'b0;
            r_bank     <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_vs_d     <= per_frame_vsync;
            r_vs_armed <= r_vs_armed | ~per_frame_vsync;
            r_bank     <= r_bank ^ w_commit;
            r_valid    <= r_valid | w_commit;
        end
    end

    // Host writes always land in the shadow bank; contents are never reset
    always_ff @(posedge clk) begin
        if (cfg_we) r_lut[~r_bank][cfg_addr] <= cfg_data;
    end

    // Per-channel LUT lookup from the stage-1 captured pixel and bank
    always_comb begin
        w_lut_data = '0;
        for (int k = 0; k < CHANNELS; k++)
            w_lut_data[k*DATA_WIDTH +: DATA_WIDTH] = r_lut[r_s1_bank][r_s1_data[k*DATA_WIDTH +: DATA_WIDTH]];
    end

    // Stage 1: capture pixel, sync, and the bank/mode that apply to this pixel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_data  <= '0;
            r_s1_bank  <= 1'b0;
            r_s1_map   <= 1'b0;
            r_s1_vsync <= 1'b0;
            r_s1_href  <= 1'b0;
            r_s1_clken <= 1'b0;
        end else begin
            r_s1_data  <= per_img_data;
            r_s1_bank  <= r_bank ^ w_commit;
            r_s1_map   <= ~bypass_en & (r_valid | w_commit);
            r_s1_vsync <= per_frame_vsync;
            r_s1_href  <= per_frame_href;
            r_s1_clken <= per_frame_clken;
        end
    end

    // Stage 2: register mapped or identity data, blanked outside valid pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_post_data  <= '0;
            r_post_vsync <= 1'b0;
            r_post_href  <= 1'b0;
            r_post_clken <= 1'b0;
        end else begin
            r_post_data  <= r_s1_clken ? (r_s1_map ? w_lut_data : r_s1_data) : '0;
            r_post_vsync <= r_s1_vsync;
            r_post_href  <= r_s1_href;
            r_post_clken <= r_s1_clken;
        end
    end

    assign post_img_data    = r_post_data;
    assign post_frame_vsync = r_post_vsync;
    assign post_frame_href  = r_post_href;
    assign post_frame_clken = r_post_clken;
    assign cfg_active_bank  = r_bank;
    assign cfg_table_valid  = r_valid;
endmodule

// File: tb/tb_gamma_lut_mapper.sv
// tb_gamma_lut_mapper: directed self-checking bench for gamma_lut_mapper
module tb_gamma_lut_mapper;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        per_frame_vsync, per_frame_href, per_frame_clken;
    logic [23:0] per_img_data;
    logic        post_frame_vsync, post_frame_href, post_frame_clken;
    logic [23:0] post_img_data;
    logic        cfg_we;
    logic [7:0]  cfg_addr, cfg_data;
    logic        cfg_swap_req, bypass_en;
    logic        cfg_swap_pending, cfg_active_bank, cfg_table_valid;
    logic [7:0]  gam [256];
    int          n_pass = 0;
    int          n_total = 0;

    gamma_lut_mapper #(.DATA_WIDTH(8), .CHANNELS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
        .per_frame_clken(per_frame_clken), .per_img_data(per_img_data),
        .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
        .post_frame_clken(post_frame_clken), .post_img_data(post_img_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_swap_req(cfg_swap_req), .bypass_en(bypass_en),
        .cfg_swap_pending(cfg_swap_pending), .cfg_active_bank(cfg_active_bank),
        .cfg_table_valid(cfg_table_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            gam[i] = 8'($rtoi(255.0 * $pow(real'(i) / 255.0, 2.2) + 0.5));
        rst_n = 1'b0; per_frame_vsync = 0; per_frame_href = 0; per_frame_clken = 0;
        per_img_data = '0; cfg_we = 0; cfg_addr = '0; cfg_data = '0;
        cfg_swap_req = 0; bypass_en = 0;
        tick(); tick();
        chk("rst_post_data", post_img_data, 0);
        chk("rst_bank", cfg_active_bank, 0);
        chk("rst_pending", cfg_swap_pending, 0);
        chk("rst_valid", cfg_table_valid, 0);
        rst_n = 1'b1;
        tick();
        // identity before any commit
        per_img_data = 24'h8010FF; per_frame_href = 1; per_frame_clken = 1;
        tick();
        per_img_data = 24'h123456; per_frame_clken = 0;
        tick();
        chk("id_data", post_img_data, 24'h8010FF);
        chk("id_clken", post_frame_clken, 1);
        chk("id_href", post_frame_href, 1);
        chk("id_vsync", post_frame_vsync, 0);
        chk("id_valid", cfg_table_valid, 0);
        tick();
        chk("blank_data", post_img_data, 0);
        chk("blank_clken", post_frame_clken, 0);
        // load gamma curve into shadow bank 1 and commit at vsync
        per_frame_href = 0;
        for (int i = 0; i < 256; i++) begin
            cfg_we = 1; cfg_addr = 8'(i); cfg_data = gam[i];
            tick();
        end
        cfg_we = 0; cfg_swap_req = 1;
        tick();
        cfg_swap_req = 0;
        chk("g_pending", cfg_swap_pending, 1);
        chk("g_bank_pre", cfg_active_bank, 0);
        tick();
        chk("g_pending_hold", cfg_swap_pending, 1);
        per_frame_vsync = 1; per_frame_clken = 1; per_img_data = 24'h808080;
        tick();
        chk("g_bank", cfg_active_bank, 1);
        chk("g_valid", cfg_table_valid, 1);
        chk("g_pending_clr", cfg_swap_pending, 0);
        per_img_data = 24'h40FF0F;
        tick();
        chk("g_map80", post_img_data, 24'h383838);
        chk("g_post_vsync", post_frame_vsync, 1);
        per_frame_vsync = 0;
        tick();
        chk("g_map40FF0F", post_img_data, 24'h0CFF01);
        // inverse curve into bank 0, mid-frame request, write while pending
        per_frame_clken = 0;
        for (int i = 0; i < 256; i++) begin
            cfg_we = 1; cfg_addr = 8'(i); cfg_data = 8'(255 - i);
            tick();
        end
        cfg_we = 0; cfg_swap_req = 1; per_frame_clken = 1; per_img_data = 24'h808080;
        tick();
        cfg_swap_req = 0;
        chk("m_pending", cfg_swap_pending, 1);
        chk("m_bank_hold", cfg_active_bank, 1);
        cfg_we = 1; cfg_addr = 8'h80; cfg_data = 8'h11;
        tick();
        cfg_we = 0;
        chk("m_old_curve", post_img_data, 24'h383838);
        chk("m_pending_wr", cfg_swap_pending, 1);
        per_frame_vsync = 1; per_img_data = 24'h804000;
        tick();
        chk("m_bank", cfg_active_bank, 0);
        chk("m_pending_clr", cfg_swap_pending, 0);
        per_img_data = 24'h000000;
        tick();
        chk("m_new_curve", post_img_data, 24'h11BFFF);
        // request coincident with vsync edge, then duplicate request while pending
        per_frame_vsync = 0;
        tick();
        per_frame_vsync = 1; cfg_swap_req = 1;
        tick();
        chk("s_bank", cfg_active_bank, 1);
        chk("s_pending", cfg_swap_pending, 0);
        per_frame_vsync = 0; cfg_swap_req = 0;
        tick();
        cfg_swap_req = 1;
        tick();
        tick();
        cfg_swap_req = 0;
        chk("d_pending", cfg_swap_pending, 1);
        chk("d_bank_hold", cfg_active_bank, 1);
        per_frame_vsync = 1;
        tick();
        chk("d_bank", cfg_active_bank, 0);
        chk("d_pending_clr", cfg_swap_pending, 0);
        tick();
        chk("d_no_retoggle", cfg_active_bank, 0);
        // bypass toggled per pixel, with a blanked pixel
        per_frame_vsync = 0; per_frame_href = 1; per_frame_clken = 1;
        per_img_data = 24'h202020; bypass_en = 1;
        tick();
        bypass_en = 0;
        tick();
        chk("b_identity", post_img_data, 24'h202020);
        per_img_data = 24'h555555; per_frame_clken = 0; bypass_en = 1;
        tick();
        chk("b_mapped", post_img_data, 24'hDFDFDF);
        per_img_data = 24'h804000; per_frame_clken = 1; bypass_en = 0;
        tick();
        chk("b_blank_data", post_img_data, 0);
        chk("b_blank_clken", post_frame_clken, 0);
        per_frame_clken = 0;
        tick();
        chk("b_mapped2", post_img_data, 24'h11BFFF);
        // reset mid-line with swap pending and vsync high at release
        per_frame_clken = 1; per_img_data = 24'h808080; cfg_swap_req = 1;
        tick();
        cfg_swap_req = 0;
        tick();
        chk("r_pre_pending", cfg_swap_pending, 1);
        chk("r_pre_clken", post_frame_clken, 1);
        per_frame_vsync = 1;
        #2 rst_n = 0;
        #1;
        chk("r_data", post_img_data, 0);
        chk("r_syncs", {post_frame_vsync, post_frame_href, post_frame_clken}, 0);
        chk("r_cfg", {cfg_swap_pending, cfg_active_bank, cfg_table_valid}, 0);
        tick();
        rst_n = 1; cfg_swap_req = 1;
        tick();
        cfg_swap_req = 0;
        chk("r_no_commit_bank", cfg_active_bank, 0);
        chk("r_no_commit_pend", cfg_swap_pending, 1);
        chk("r_no_commit_valid", cfg_table_valid, 0);
        tick();
        chk("r_identity", post_img_data, 24'h808080);
        per_frame_vsync = 0;
        tick();
        per_frame_vsync = 1;
        tick();
        chk("r_commit_bank", cfg_active_bank, 1);
        chk("r_commit_valid", cfg_table_valid, 1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
